// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared constants and types for the block-RAM backed FIFO controller.
package bram_fifo_ctrl_pkg;

  localparam int FIFO_ADDR_W = 8;
  localparam int FIFO_DATA_W = 16;
  localparam int FIFO_DEPTH  = 256;

  // Occupancy needs one extra bit so that a completely full FIFO (256) is representable.
  typedef logic [FIFO_ADDR_W:0] count_t;

endpackage : bram_fifo_ctrl_pkg

// File: rtl/bram_fifo_ctrl.sv
// Synchronous FIFO controller driving an external 256x16 block RAM with a
// registered read port. The RAM is outside this block; only its ports are driven here.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W     = FIFO_ADDR_W,
  parameter int DATA_W     = FIFO_DATA_W,
  parameter int AFULL_LVL  = 240,
  parameter int AEMPTY_LVL = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0]   CNT_ZERO  = '0;
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0]   CNT_AFULL = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0]   CNT_AEMPT = (ADDR_W+1)'(AEMPTY_LVL);
  localparam logic [ADDR_W-1:0] PTR_ZERO  = '0;
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              rd_valid_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Flags derive only from the registered occupancy, never from this cycle's requests.
  assign full         = (count_r == CNT_DEPTH);
  assign empty        = (count_r == CNT_ZERO);
  assign almost_full  = (count_r >= CNT_AFULL);
  assign almost_empty = (count_r <= CNT_AEMPT);

  // A push is never accepted during reset so the RAM sees no write in that cycle.
  // Because a pop needs count>0 and a push needs count<256, the write and read
  // addresses can never collide in an accepted cycle.
  assign push_ok_s = wr_en & ~full & ~rst;
  assign pop_ok_s  = rd_en & ~empty;

  assign mem_we    = push_ok_s;
  assign mem_waddr = wr_ptr_r;
  assign mem_wdata = wr_data;
  assign mem_raddr = rd_ptr_r;

  // The RAM registers rdata at the pop edge, so it lines up with rd_valid directly.
  assign rd_data   = mem_rdata;
  assign rd_valid  = rd_valid_r;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

  // Pointer, occupancy, read-valid pipeline and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end

      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end

      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase

      rd_valid_r  <= pop_ok_s;
      overflow_r  <= overflow_r | (wr_en & full);
      underflow_r <= underflow_r | (rd_en & empty);
    end
  end

endmodule : bram_fifo_ctrl

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly in front of one 256x16 block-RAM wrapper instance.
- Drives the RAM write port (waddr/we/wdata) and read port address (raddr), and consumes the RAM rdata.
- Presents a push/pop FIFO interface with full/empty/almost flags, occupancy count and sticky error flags.
- Top level wires the RAM's rclk and wclk both to clk; storage is not instantiated inside this block.

Parameters:
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W = 256.
- DATA_W, 16, word width; must match the RAM data width.
- AFULL_LVL, 240, almost_full asserted when count >= AFULL_LVL.
- AEMPTY_LVL, 16, almost_empty asserted when count <= AEMPTY_LVL.

Ports:
- clk  in  1  single clock for the FIFO logic and both RAM ports.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push request.
- wr_data  in  DATA_W  push data.
- rd_en  in  1  pop request.
- rd_data  out  DATA_W  popped word; equals mem_rdata.
- rd_valid  out  1  rd_data valid this cycle.
- full  out  1  count == 256.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LVL.
- almost_empty  out  1  count <= AEMPTY_LVL.
- count  out  ADDR_W+1  occupancy, 0..256.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.
- mem_waddr  out  ADDR_W  to RAM waddr.
- mem_we  out  1  to RAM we.
- mem_wdata  out  DATA_W  to RAM wdata.
- mem_raddr  out  ADDR_W  to RAM raddr.
- mem_rdata  in  DATA_W  from RAM rdata; registered in the RAM, 1-cycle latency.

Behaviour:
- Reset (rst=1 at a clk edge) sets wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, overflow=0, underflow=0.
- Out of reset the flags read empty=1, full=0, almost_empty=1, almost_full=0.
- Flags are combinational from the registered count.
- Accept rules, evaluated on current-cycle flags:
  - push_ok = wr_en & !full
  - pop_ok = rd_en & !empty
- Write path:
  - mem_we = push_ok, mem_waddr = wr_ptr, mem_wdata = wr_data (combinational).
  - On push_ok, wr_ptr increments mod 256 (natural 8-bit wrap).
- Read path:
  - mem_raddr = rd_ptr (combinational).
  - On pop_ok, rd_ptr increments mod 256.
  - rd_valid is registered from pop_ok, so it is high exactly one cycle after the pop cycle.
  - rd_data = mem_rdata, which the RAM latched at rd_ptr on that edge.
  - Total latency: pop request to data is 1 cycle.
  - When rd_valid=0, rd_data is don't-care.
- Count update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - both or neither: unchanged.
- Simultaneous push and pop:
  - When full, only the pop is accepted; count becomes 255 and overflow is set.
  - When empty, only the push is accepted; there is no bypass. count becomes 1, underflow is set, and rd_valid stays 0 next cycle.
- Read/write address collision: cannot occur, because a pop needs count>0 and a push needs count<256.
- Write-to-read latency: a word pushed in cycle N can be popped in N+1 at the earliest, with data valid in N+2.
- Sticky flags:
  - overflow is set on wr_en & full; underflow is set on rd_en & empty.
  - Both clear only on rst.
- Reset mid-operation:
  - Pending rd_valid is dropped and all contents are logically discarded.
  - mem_we is 0 during the reset cycle.
  - RAM contents are not cleared.

Decomposition:
- Shared package holds:
  - FIFO_ADDR_W=8, FIFO_DATA_W=16, FIFO_DEPTH=256.
  - A count typedef of width ADDR_W+1.
- No sub-module. A single always block for pointers, count, rd_valid and sticky flags, plus continuous assigns for flags and RAM ports.

Test Plan:
- Reset, then idle 5 cycles -> empty=1, count=0, rd_valid=0, mem_we=0, overflow=underflow=0.
- Push 0x1234, 0xBEEF, then pop twice back-to-back -> rd_valid high in the two cycles after each pop, with rd_data 0x1234 then 0xBEEF; count ends at 0 and empty=1.
- Push 256 words (value = index) -> full=1, count=256, almost_full asserted from count 240. A 257th push sets overflow=1 with no mem_we.
- Full FIFO with wr_en=rd_en=1 for one cycle -> count=255, overflow=1. The popped word is 0x0000 (index 0), valid the next cycle.
- Drain across wrap: push 200, pop 200, push 100, pop 100 -> the data sequence is intact across the pointer wrap 255->0.
- Empty FIFO with rd_en=1 and wr_en=1 (data 0x00AA) -> underflow=1, count=1, rd_valid=0. Assert rst during a subsequent pop -> rd_valid=0 next cycle, count=0.
